// File: rtl/clk_gate_ctrl_if.sv
// Request/activity/enable bundle shared by the system controller and the
// clock-gate enable controller.
interface clk_gate_ctrl_if;
  logic       req;
  logic       busy;
  logic       test_en;
  logic       clk_en;
  logic       clk_rdy;
  logic [1:0] gate_state;

  // Requester side: drives request, activity and test force, observes the gate.
  modport master (
    output req,
    output busy,
    output test_en,
    input  clk_en,
    input  clk_rdy,
    input  gate_state
  );

  // Controller side.
  modport slave (
    input  req,
    input  busy,
    input  test_en,
    output clk_en,
    output clk_rdy,
    output gate_state
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: wakes the gated domain on request, holds it
// while busy plus a hang-over interval, then switches the gate cell off.
module clk_gate_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  clk_gate_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_OFF  = 2'b00;
  localparam logic [1:0] ST_WAKE = 2'b01;
  localparam logic [1:0] ST_ON   = 2'b10;
  localparam logic [1:0] ST_HOLD = 2'b11;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             enable_reg, enable_next;
  logic             rdy_reg, rdy_next;
  logic             active;
  logic             cnt_done;

  assign active   = bus.req | bus.busy;
  assign cnt_done = (cnt_reg == CNT_ZERO);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_OFF: begin
        // BUSY deliberately ignored here: only the requester may wake the domain.
        if (bus.req) begin
          state_next = ST_WAKE;
          cnt_next   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_done) begin
          state_next = ST_ON;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      ST_ON: begin
        if (!active) begin
          state_next = ST_HOLD;
          cnt_next   = IDLE_LOAD;
        end
      end
      ST_HOLD: begin
        // Renewed activity beats expiry, so the clock never blinks off.
        if (active) begin
          state_next = ST_ON;
        end else if (cnt_done) begin
          state_next = ST_OFF;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = ST_OFF;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  assign enable_next = (state_next != ST_OFF);
  assign rdy_next    = (state_next == ST_ON) || (state_next == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_OFF;
      cnt_reg    <= CNT_ZERO;
      enable_reg <= 1'b0;
      rdy_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      enable_reg <= enable_next;
      rdy_reg    <= rdy_next;
    end
  end

  // The test force is the only combinational term reaching the gate cell.
  assign bus.clk_en     = enable_reg | bus.test_en;
  assign bus.clk_rdy    = rdy_reg;
  assign bus.gate_state = state_reg;

endmodule
